// File: rtl/mdu_ctrl.sv
// Multi-cycle multiply/divide sequencer for the MIPS execute stage.
// Owns HI/LO; the result is computed at issue and revealed only when the busy window closes.
module mdu_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        md_use,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  // state | meaning
  // IDLE  | accepts mult/div/mthi/mtlo
  // MULT  | multiply latency window, result pending
  // DIV   | divide latency window, result pending
  typedef enum logic [1:0] {IDLE, MULT, DIV} state_t;

  localparam logic [4:0] MULT_CNT = 5'(MULT_CYCLES);
  localparam logic [4:0] DIV_CNT  = 5'(DIV_CYCLES);

  state_t      state;
  logic [4:0]  count;
  logic [31:0] pend_hi;
  logic [31:0] pend_lo;
  logic        pend_wr;

  logic        is_mul, is_div, is_mthi, is_mtlo, op_signed;
  logic [63:0] a_ext, b_ext, product;
  logic        a_neg, b_neg, div_zero;
  logic [31:0] a_mag, b_mag, b_safe, q_mag, r_mag, quot, rem;

  always_comb begin
    is_mul    = (md_op[2:1] == 2'b00);
    is_div    = (md_op[2:1] == 2'b01);
    is_mthi   = (md_op == 3'b100);
    is_mtlo   = (md_op == 3'b101);
    op_signed = ~md_op[0];
  end

  // Sign/zero extension to 64 bits makes one truncated multiply serve both mult and multu.
  always_comb begin
    a_ext   = {{32{op_signed & rs_val[31]}}, rs_val};
    b_ext   = {{32{op_signed & rt_val[31]}}, rt_val};
    product = a_ext * b_ext;
  end

  // Magnitude division; 0x80000000/-1 wraps naturally to 0x80000000 with remainder 0.
  always_comb begin
    a_neg    = op_signed & rs_val[31];
    b_neg    = op_signed & rt_val[31];
    a_mag    = a_neg ? (32'd0 - rs_val) : rs_val;
    b_mag    = b_neg ? (32'd0 - rt_val) : rt_val;
    div_zero = (rt_val == 32'd0);
    b_safe   = div_zero ? 32'd1 : b_mag;
    q_mag    = a_mag / b_safe;
    r_mag    = a_mag % b_safe;
    quot     = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
    rem      = a_neg ? (32'd0 - r_mag) : r_mag;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      count   <= 5'd0;
      busy    <= 1'b0;
      hi      <= 32'd0;
      lo      <= 32'd0;
      pend_hi <= 32'd0;
      pend_lo <= 32'd0;
      pend_wr <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (is_mul) begin
              pend_hi <= product[63:32];
              pend_lo <= product[31:0];
              pend_wr <= 1'b1;
              count   <= MULT_CNT;
              state   <= MULT;
              busy    <= 1'b1;
            end else if (is_div) begin
              pend_hi <= rem;
              pend_lo <= quot;
              pend_wr <= ~div_zero;
              count   <= DIV_CNT;
              state   <= DIV;
              busy    <= 1'b1;
            end else if (is_mthi) begin
              hi <= rs_val;
            end else if (is_mtlo) begin
              lo <= rs_val;
            end
          end
        end
        MULT, DIV: begin
          if (count == 5'd1) begin
            if (pend_wr) begin
              hi <= pend_hi;
              lo <= pend_lo;
            end
            count <= 5'd0;
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            count <= count - 5'd1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          count <= 5'd0;
        end
      endcase
    end
  end

  // Combinational so the dependent D-stage instruction holds in the issue cycle too.
  assign stall = md_use & (start | busy);

endmodule

// File: tb/tb_mdu_ctrl.sv
// Scoreboard bench for mdu_ctrl: results queued at issue, checked when busy falls.
module tb_mdu_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  md_op = 3'b000;
  logic [31:0] rs_val = 32'd0;
  logic [31:0] rt_val = 32'd0;
  logic        md_use = 1'b0;
  logic        busy, stall;
  logic [31:0] hi, lo;

  int n_cmp = 0;
  int n_fail = 0;
  logic [63:0] exp_q[$];
  logic        prev_busy = 1'b0;

  localparam logic [2:0] OP_MULT = 3'b000, OP_MULTU = 3'b001, OP_DIV = 3'b010,
                         OP_DIVU = 3'b011, OP_MTHI = 3'b100, OP_MTLO = 3'b101;

  mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .md_op(md_op),
    .rs_val(rs_val), .rt_val(rt_val), .md_use(md_use),
    .busy(busy), .stall(stall), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every busy 1->0 transition presents a result to be scored.
  always @(negedge clk) begin
    if (prev_busy && !busy) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_result: got hi=0x%08h lo=0x%08h with empty queue", hi, lo);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        chk("result_hi", hi, e[63:32]);
        chk("result_lo", lo, e[31:0]);
      end
    end
    prev_busy <= busy;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    start  = 1'b1;
    md_op  = op;
    rs_val = a;
    rt_val = b;
    tick();
    start  = 1'b0;
  endtask

  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                        input int cycles);
    int n;
    exp_q.push_back({eh, el});
    issue(op, a, b);
    n = 0;
    while (n < 40) begin
      @(negedge clk);
      if (!busy) break;
      n++;
    end
    chk({name, "_busy_cycles"}, 32'(n), 32'(cycles));
    tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    // Reset state; stall is md_use&start even while reset is held.
    tick();
    md_use = 1'b1;
    start  = 1'b1;
    md_op  = 3'b110;
    @(negedge clk);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_hi", hi, 32'd0);
    chk("reset_lo", lo, 32'd0);
    chk("reset_stall", {31'd0, stall}, 32'd1);
    tick();
    start  = 1'b0;
    md_use = 1'b0;
    reset  = 1'b0;
    tick();

    run_op("multu_ff_x2", OP_MULTU, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'hFFFF_FFFE, 5);
    run_op("mult_m3_x7",  OP_MULT,  32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 5);
    run_op("multu_fd_x7", OP_MULTU, 32'hFFFF_FFFD, 32'h0000_0007, 32'h0000_0006, 32'hFFFF_FFEB, 5);
    run_op("div_m7_2",    OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
    run_op("divu_100_7",  OP_DIVU,  32'd100,       32'd7,         32'd2,         32'd14,        10);
    run_op("div_ovf",     OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 10);

    // Reserved opcode leaves everything alone.
    issue(3'b111, 32'hDEAD_BEEF, 32'h1);
    @(negedge clk);
    chk("rsvd_busy", {31'd0, busy}, 32'd0);
    chk("rsvd_hi", hi, 32'h0000_0000);
    chk("rsvd_lo", lo, 32'h8000_0000);
    tick();

    // mtlo then divide by zero.
    do_reset();
    issue(OP_MTLO, 32'h0000_1234, 32'h0);
    @(negedge clk);
    chk("mtlo_lo", lo, 32'h0000_1234);
    chk("mtlo_hi", hi, 32'h0000_0000);
    chk("mtlo_busy", {31'd0, busy}, 32'd0);
    tick();
    run_op("divu_by0", OP_DIVU, 32'd5, 32'd0, 32'h0000_0000, 32'h0000_1234, 10);

    // Stall window plus an ignored start during busy.
    md_use = 1'b1;
    start  = 1'b1;
    md_op  = OP_MULT;
    rs_val = 32'd3;
    rt_val = 32'd4;
    exp_q.push_back({32'd0, 32'd12});
    @(negedge clk);
    chk("stall_issue", {31'd0, stall}, 32'd1);
    tick();
    start = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      if (c == 2) begin
        start  = 1'b1;
        md_op  = OP_DIV;
        rs_val = 32'd100;
        rt_val = 32'd7;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      chk($sformatf("stall_busy_c%0d", c), {31'd0, busy}, (c <= 5) ? 32'd1 : 32'd0);
      chk($sformatf("stall_c%0d", c), {31'd0, stall}, (c <= 5) ? 32'd1 : 32'd0);
      tick();
    end
    start = 1'b0;

    // Reset during busy cycle 3 of a divide discards the result.
    issue(OP_DIV, 32'd100, 32'd7);
    exp_q.push_back({32'd0, 32'd0});
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("rst_mid_busy_c3", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    chk("rst_mid_stall", {31'd0, stall}, 32'd0);
    tick();
    issue(OP_MTHI, 32'hABCD_0000, 32'h0);
    @(negedge clk);
    chk("mthi_hi", hi, 32'hABCD_0000);
    chk("mthi_lo", lo, 32'h0000_0000);
    md_use = 1'b0;
    tick();
    tick();

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
- Multi-cycle multiply/divide controller for the execute stage of the five-stage pipelined MIPS CPU.
- Accepts mult/multu/div/divu/mthi/mtlo from E and sequences a fixed-latency operation.
- Owns the HI/LO architectural registers.
- Raises a stall request to the hazard unit while a younger HI/LO user must wait.

Parameters:
MULT_CYCLES, 5, busy cycles for mult/multu (legal range 1..31)
DIV_CYCLES, 10, busy cycles for div/divu (legal range 1..31)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
start  input  1  E-stage holds a valid HI/LO-writing instruction this cycle
md_op  input  3  000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo, others reserved
rs_val  input  32  forwarded rs operand (dividend / multiplicand / mthi-mtlo source)
rt_val  input  32  forwarded rt operand (divisor / multiplier)
md_use  input  1  D-stage instruction is mult/div/mfhi/mflo/mthi/mtlo
busy  output  1  multi-cycle operation in progress
stall  output  1  stall request to the hazard unit
hi  output  32  HI register
lo  output  32  LO register

Behaviour:
- One clock (clk). Reset is synchronous and active-high. On reset: state IDLE, counter 0, hi=0, lo=0, busy=0; stall is combinational and evaluates to md_use&start.
- FSM states: IDLE, MULT, DIV. Counter is 5 bits.
- IDLE, start=1, md_op mult/multu at edge T:
  - Latch 64-bit product. mult is signed; multu is unsigned.
  - counter=MULT_CYCLES; enter MULT.
- IDLE, start=1, md_op div/divu at edge T:
  - Latch quotient and remainder. Signed div truncates toward zero; remainder takes the dividend's sign.
  - counter=DIV_CYCLES; enter DIV.
- MULT/DIV: counter decrements each cycle. At the edge where counter==1:
  - hi/lo load the pending result (HI=upper product or remainder; LO=lower product or quotient).
  - Return to IDLE.
- Timing: busy=1 for exactly N cycles (T+1..T+N). New hi/lo and busy=0 both appear in cycle T+N+1.
- mthi/mtlo in IDLE: write hi (or lo) with rs_val at the same edge. Value is visible the next cycle; no busy; the other register is unchanged.
- Divide by zero (rt_val==0): full DIV_CYCLES busy sequence still runs; hi/lo left unchanged at completion.
- div 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- Reserved md_op: ignored, no state change.
- start while busy=1: ignored. Protocol violation, prevented by stall; hi/lo and counter undisturbed.
- stall = md_use & (start | busy). Combinational, so the D-stage instruction stalls in the issue cycle as well.
- Reset mid-operation: pending result discarded, hi/lo cleared to 0, busy=0 the next cycle.
- Pending result is held in internal registers only; hi/lo never show partial values.

Test Plan:
- Reset, then multu rs=0xFFFFFFFF rt=0x00000002 -> busy high exactly 5 cycles; then hi=0x00000001, lo=0xFFFFFFFE, busy=0.
- mult rs=0xFFFFFFFD (-3) rt=0x00000007 -> after 5 cycles hi=0xFFFFFFFF, lo=0xFFFFFFEB. Same operands with multu -> hi=0x00000006, lo=0xFFFFFFEB.
- div rs=0xFFFFFFF9 (-7) rt=0x00000002 -> busy 10 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu 100/7 -> lo=14, hi=2.
- mtlo 0x1234 then divu rs=5 rt=0 -> lo=0x1234 the next cycle; busy 10 cycles; hi/lo unchanged afterwards (hi=0, lo=0x1234).
- Start mult, hold md_use=1 -> stall=1 in the issue cycle and all 5 busy cycles, 0 the cycle after. Pulse start with div at busy cycle 2 -> ignored; mult result still lands after 5 cycles.
- Start div, assert reset in busy cycle 3 -> next cycle busy=0, hi=0, lo=0, stall=0. Then mthi rs=0xABCD0000 -> hi=0xABCD0000 one cycle later, lo=0.
